answer_period: RTL
==================

# answer_period

Answer-phase controller that pairs with the game-period block. It accepts the end-of-game `answerSig` pulse and the latched special-symbol count, then runs a timed entry window in which the player enters a count with up/down/submit buttons. It grades the entry, shows the result on the four 7-segment digits and keeps a running score. Its `doneSig` pulse returns control to the top-level game sequencer.

## Interface
- `TIMEOUT_S`, 10: answer window length in 1 Hz ticks (1..10).
- `SHOW_S`, 3: result display length in 1 Hz ticks (≥1).
- `Clk100M`  in  1  system clock; all logic in this single domain.
- `ResetN`  in  1  reset, asynchronous assert, active-low.
- `tick1Hz`  in  1  one-cycle enable pulse per second, synchronous to `Clk100M`.
- `answerSig`  in  1  one-cycle pulse that starts the answer phase.
- `numSpecial`  in  8  count of special symbols; sampled on `answerSig`.
- `btnUp`, `btnDown`, `btnSubmit`  in  1 each  debounced, synchronous level inputs.
- `ansSeg0..ansSeg3`  out  8 each  active-low segment patterns (bit7 = dp, bits6..0 = gfedcba). `ansSeg0` is the rightmost digit.
- `busy`  out  1  high in every state except IDLE.
- `correct`, `wrong`  out  1 each  one-cycle grade pulses.
- `score`  out  8  correct-answer count, saturates at 255.
- `doneSig`  out  1  one-cycle pulse when the phase ends.

## Operation
- Segment codes:
  - Digits 0–9: C0 F9 A4 B0 99 92 82 F8 80 90 (hex).
  - Blank: FF. PASS glyph 'P': 8C. FAIL glyph 'F': 8E.
- FSM states are IDLE, ANSWER, CHECK, SHOW.
- **IDLE**
  - All segments blank.
  - `answerSig` latches `numSpecial` into `target`, sets `guess`=0 and `remain`=`TIMEOUT_S`-1, then moves to ANSWER.
- **ANSWER**
  - Button action is taken on the rising edge of each button. Edges are detected against a one-cycle registered copy of the button.
  - Up edge: `guess`+1, saturating at 99. Down edge: `guess`-1, saturating at 0.
  - Up and down edges in the same cycle: no change.
  - A submit edge moves to CHECK. Any up/down edge in the same cycle is discarded, so the pre-edge `guess` is graded.
  - On `tick1Hz` with `remain`>0, `remain` decrements.
  - On `tick1Hz` with `remain`==0 (timeout), the FSM moves to CHECK. If a submit edge occurs in the same cycle, the result is identical: a single CHECK.
  - Display: seg3 blank, seg2 shows `remain`, seg1 shows guess tens, seg0 shows guess ones.
- **CHECK** (exactly one cycle)
  - If `guess`==`target` (full 8-bit compare): pulse `correct` and increment `score` (saturating).
  - Otherwise pulse `wrong`.
  - Then move to SHOW with the show counter set to `SHOW_S`.
  - A `target` above 99 can never match. This is intended.
- **SHOW**
  - Display: seg3 shows P or F, seg2 blank, seg1/seg0 show `target` clamped to 99.
  - The counter decrements on each `tick1Hz`.
  - On the tick that takes the counter to 0: pulse `doneSig` and return to IDLE.
- `answerSig` is ignored whenever `busy` is high.
- Reset values:
  - State IDLE; `guess`, `target`, `remain`, show counter and `score` all 0.
  - Every `ansSeg` = FF; all pulses and `busy` 0.
  - Button edge registers cleared. A button held through reset release produces no edge.
- Reset asserted mid-phase returns the block to IDLE immediately and clears `score`.

## Timing
- `answerSig` high in cycle N → `busy` high and ANSWER display valid in N+1.
- First button cycle high at k (low at k−1) → new `guess` visible in k+1. Holding the button gives no repeat.
- Submit edge at cycle k → CHECK at k+1 → `correct`/`wrong` and the updated `score` registered at k+2. SHOW display is valid at k+2.
- `doneSig` and `busy` falling occur one cycle after the final SHOW tick.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Shared package `symcounter_pkg` holds:
  - The state enum.
  - The segment constants: `SEG_BLANK`, `SEG_P`, `SEG_F` and the digit table.
  - `MAX_GUESS`=99.
- One sub-module, `seg7_digit`, maps a 4-bit value (0–9, others → blank) to an 8-bit pattern. It is instantiated four times.
- Tens/ones split is by constant compare-subtract on a 0..99 value. No general divider.

## Test plan
- `numSpecial`=5, `answerSig`, 5 up edges, submit → `correct` pulse, `score`=1, seg3=8C, seg1/seg0=C0/92, `doneSig` after 3 ticks.
- `numSpecial`=3, 2 up edges, submit → `wrong` pulse, `score` unchanged, seg3=8E.
- No buttons, 10 ticks → timeout grades `guess`=0. With `numSpecial`=0 → `correct`. seg2 counts 90 (9) down to C0 (0).
- Saturation: 3 down edges at 0 → `guess` stays 0. 105 up edges → `guess`=99. Simultaneous up+down → no change. Submit+up in the same cycle → pre-edge value graded.
- `answerSig` during SHOW is ignored. `ResetN` low mid-ANSWER → all segments FF, `busy`=0, `score`=0 asynchronously.
- `numSpecial`=150 with `guess`=99 submitted → `wrong`, and seg1/seg0 show 99.

Source files
------------

// File: rtl/symcounter_pkg.sv
// Shared types and constants for the symbol-counter game: answer FSM states,
// 7-segment codes and the decimal split used by the answer-phase display.
package symcounter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ANSWER = 2'd1,
        ST_CHECK  = 2'd2,
        ST_SHOW   = 2'd3
    } state_t;

    // Active-low patterns, bit7 = dp, bits6..0 = gfedcba
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_P     = 8'h8C;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_DIGITS [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    localparam logic [7:0] MAX_GUESS   = 8'd99;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Clamps to 99, then peels off the tens by constant compare-subtract.
    // Returns {tens, ones} as two 4-bit digits.
    function automatic logic [7:0] splitDecimal(input logic [7:0] value);
        logic [7:0] rest;
        logic [3:0] tens;
        rest = (value > MAX_GUESS) ? MAX_GUESS : value;
        tens = 4'd0;
        for (int t = 9; t >= 1; t--) begin
            if (tens == 4'd0 && rest >= 8'(t * 10)) begin
                tens = 4'(t);
                rest = rest - 8'(t * 10);
            end
        end
        return {tens, rest[3:0]};
    endfunction

endpackage

// File: rtl/seg7_digit.sv
// Maps one decimal digit to its active-low 7-segment pattern; values above 9
// produce a blank digit.
module seg7_digit
    import symcounter_pkg::*;
(
    input  logic [3:0] value,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (value <= 4'd9) begin
            seg = SEG_DIGITS[value];
        end
    end

endmodule

// File: rtl/answer_period.sv
// Answer-phase controller: timed guess entry with up/down/submit buttons,
// grading against the latched symbol count, result display and running score.
module answer_period
    import symcounter_pkg::*;
#(
    parameter int TIMEOUT_S = 10,
    parameter int SHOW_S    = 3
) (
    input  logic       Clk100M,
    input  logic       ResetN,
    input  logic       tick1Hz,
    input  logic       answerSig,
    input  logic [7:0] numSpecial,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnSubmit,
    output logic [7:0] ansSeg0,
    output logic [7:0] ansSeg1,
    output logic [7:0] ansSeg2,
    output logic [7:0] ansSeg3,
    output logic       busy,
    output logic       correct,
    output logic       wrong,
    output logic [7:0] score,
    output logic       doneSig
);

    localparam logic [3:0] REMAIN_INIT = 4'(TIMEOUT_S - 1);
    localparam logic [7:0] SHOW_INIT   = 8'(SHOW_S);

    state_t     state, stateNxt;
    logic [7:0] guess, guessNxt;
    logic [7:0] target, targetNxt;
    logic [3:0] remain, remainNxt;
    logic [7:0] showCnt, showCntNxt;
    logic [7:0] scoreNxt;
    logic       passed, passedNxt;
    logic       upQ, downQ, submitQ;
    logic       upEdge, downEdge, submitEdge;
    logic       match;

    logic       correctNxt, wrongNxt, doneNxt, busyNxt;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic [7:0] segRaw3, segRaw2, segRaw1, segRaw0, seg3Nxt;
    logic [7:0] splitVal;

    assign upEdge     = btnUp & ~upQ;
    assign downEdge   = btnDown & ~downQ;
    assign submitEdge = btnSubmit & ~submitQ;
    assign match      = (guess == target);

    // State register
    always_ff @(posedge Clk100M or negedge ResetN) begin
        if (!ResetN) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // Next-state logic
    always_comb begin
        stateNxt = state;
        case (state)
            ST_IDLE:   if (answerSig) stateNxt = ST_ANSWER;
            ST_ANSWER: if (submitEdge || (tick1Hz && remain == 4'd0)) stateNxt = ST_CHECK;
            ST_CHECK:  stateNxt = ST_SHOW;
            ST_SHOW:   if (tick1Hz && showCnt <= 8'd1) stateNxt = ST_IDLE;
            default:   stateNxt = ST_IDLE;
        endcase
    end

    // Datapath next values; a submit edge swallows same-cycle up/down edges
    always_comb begin
        guessNxt   = guess;
        targetNxt  = target;
        remainNxt  = remain;
        showCntNxt = showCnt;
        scoreNxt   = score;
        passedNxt  = passed;
        case (state)
            ST_IDLE: begin
                if (answerSig) begin
                    targetNxt = numSpecial;
                    guessNxt  = 8'd0;
                    remainNxt = REMAIN_INIT;
                end
            end
            ST_ANSWER: begin
                if (!submitEdge) begin
                    if (upEdge && !downEdge && guess < MAX_GUESS) begin
                        guessNxt = guess + 8'd1;
                    end else if (downEdge && !upEdge && guess != 8'd0) begin
                        guessNxt = guess - 8'd1;
                    end
                end
                if (tick1Hz && remain != 4'd0) begin
                    remainNxt = remain - 4'd1;
                end
            end
            ST_CHECK: begin
                showCntNxt = SHOW_INIT;
                passedNxt  = match;
                if (match && score != 8'hFF) begin
                    scoreNxt = score + 8'd1;
                end
            end
            ST_SHOW: begin
                if (tick1Hz && showCnt != 8'd0) begin
                    showCntNxt = showCnt - 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Output logic, computed from next values so every output is a register
    always_comb begin
        correctNxt = (state == ST_CHECK) && match;
        wrongNxt   = (state == ST_CHECK) && !match;
        doneNxt    = (state == ST_SHOW) && (stateNxt == ST_IDLE);
        busyNxt    = (stateNxt != ST_IDLE);
        digit3     = DIGIT_BLANK;
        digit2     = DIGIT_BLANK;
        digit1     = DIGIT_BLANK;
        digit0     = DIGIT_BLANK;
        splitVal   = 8'd0;
        case (stateNxt)
            ST_ANSWER, ST_CHECK: begin
                splitVal = splitDecimal(guessNxt);
                digit2   = remainNxt;
                digit1   = splitVal[7:4];
                digit0   = splitVal[3:0];
            end
            ST_SHOW: begin
                splitVal = splitDecimal(targetNxt);
                digit1   = splitVal[7:4];
                digit0   = splitVal[3:0];
            end
            default: ;
        endcase
        seg3Nxt = segRaw3;
        if (stateNxt == ST_SHOW) begin
            seg3Nxt = passedNxt ? SEG_P : SEG_F;
        end
    end

    seg7_digit u_digit3 (.value(digit3), .seg(segRaw3));
    seg7_digit u_digit2 (.value(digit2), .seg(segRaw2));
    seg7_digit u_digit1 (.value(digit1), .seg(segRaw1));
    seg7_digit u_digit0 (.value(digit0), .seg(segRaw0));

    // Button history tracks the inputs in every state so a held button never edges
    always_ff @(posedge Clk100M or negedge ResetN) begin
        if (!ResetN) begin
            guess   <= 8'd0;
            target  <= 8'd0;
            remain  <= 4'd0;
            showCnt <= 8'd0;
            score   <= 8'd0;
            passed  <= 1'b0;
            upQ     <= 1'b0;
            downQ   <= 1'b0;
            submitQ <= 1'b0;
            correct <= 1'b0;
            wrong   <= 1'b0;
            doneSig <= 1'b0;
            busy    <= 1'b0;
            ansSeg3 <= SEG_BLANK;
            ansSeg2 <= SEG_BLANK;
            ansSeg1 <= SEG_BLANK;
            ansSeg0 <= SEG_BLANK;
        end else begin
            guess   <= guessNxt;
            target  <= targetNxt;
            remain  <= remainNxt;
            showCnt <= showCntNxt;
            score   <= scoreNxt;
            passed  <= passedNxt;
            upQ     <= btnUp;
            downQ   <= btnDown;
            submitQ <= btnSubmit;
            correct <= correctNxt;
            wrong   <= wrongNxt;
            doneSig <= doneNxt;
            busy    <= busyNxt;
            ansSeg3 <= seg3Nxt;
            ansSeg2 <= segRaw2;
            ansSeg1 <= segRaw1;
            ansSeg0 <= segRaw0;
        end
    end

endmodule
